// File: rtl/iterative_flagger_pkg.sv
// Shared definitions for the iterative flag unit.
// Contents: RISC-V branch funct3 encodings, the FSM state type and the
// branch decision helper used when the result is registered.
package iterative_flagger_pkg;

    localparam logic [2:0] Funct3Beq  = 3'b000;
    localparam logic [2:0] Funct3Bne  = 3'b001;
    localparam logic [2:0] Funct3Blt  = 3'b100;
    localparam logic [2:0] Funct3Bge  = 3'b101;
    localparam logic [2:0] Funct3Bltu = 3'b110;
    localparam logic [2:0] Funct3Bgeu = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    // Branch decision from the final flags; 010/011 are not branches.
    function automatic logic branch_decide(
        input logic [2:0] funct3,
        input logic       eq,
        input logic       lt,
        input logic       ult
    );
        logic taken;
        taken = 1'b0;
        case (funct3)
            Funct3Beq:  taken = eq;
            Funct3Bne:  taken = ~eq;
            Funct3Blt:  taken = lt;
            Funct3Bge:  taken = ~lt;
            Funct3Bltu: taken = ult;
            Funct3Bgeu: taken = ~ult;
            default:    taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/iterative_flagger_chunk_compare.sv
// Unsigned comparison of one CHUNK-bit slice of the two operands.
// Ports:
//   i_a, i_b  chunk operands
//   o_eq      i_a == i_b
//   o_gt      i_a >  i_b (unsigned)
//   o_lt      i_a <  i_b (unsigned)
module iterative_flagger_chunk_compare #(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic             o_eq,
    output logic             o_gt,
    output logic             o_lt
);

    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/iterative_flagger.sv
// Multi-cycle operand comparator producing signed, unsigned and equality
// flags plus a RISC-V branch decision. Operands are scanned CHUNK bits per
// cycle from the MSB chunk down; the first differing chunk decides the
// unsigned ordering.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_start                    request, sampled only when idle
//   i_input_a, i_input_b       operands, captured on an accepted start
//   i_funct3                   branch type, captured on an accepted start
//   o_busy                     scan in progress
//   o_done                     one-cycle pulse, flags valid from here
//   o_flag_*                   registered compare flags
//   o_branch_taken             registered branch decision
module iterative_flagger
    import iterative_flagger_pkg::*;
#(
    parameter int unsigned WORDSIZE      = 64,
    parameter int unsigned CHUNK         = 16,
    parameter int unsigned FIXED_LATENCY = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [WORDSIZE-1:0] i_input_a,
    input  logic [WORDSIZE-1:0] i_input_b,
    input  logic [2:0]          i_funct3,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_flag_equal,
    output logic                o_flag_not_equal,
    output logic                o_flag_greater,
    output logic                o_flag_less,
    output logic                o_flag_u_greater,
    output logic                o_flag_u_less,
    output logic                o_branch_taken
);

    localparam int unsigned N    = WORDSIZE / CHUNK;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(N - 1);

    if (CHUNK < 1 || (WORDSIZE % CHUNK) != 0) begin : g_bad_params
        $error("iterative_flagger: CHUNK must be >= 1 and divide WORDSIZE");
    end

    state_e              r_state;
    logic [WORDSIZE-1:0] r_a;
    logic [WORDSIZE-1:0] r_b;
    logic [2:0]          r_funct3;
    logic [IdxW-1:0]     r_idx;
    // Result latch: set by the first differing chunk, never overwritten after
    logic                r_found;
    logic                r_ugt;
    logic                r_ult;

    logic                r_busy;
    logic                r_done;
    logic                r_eq;
    logic                r_gt;
    logic                r_lt;
    logic                r_ugt_flag;
    logic                r_ult_flag;
    logic                r_branch;

    logic [31:0]         w_base;
    logic [WORDSIZE-1:0] w_a_sh;
    logic [WORDSIZE-1:0] w_b_sh;
    logic [CHUNK-1:0]    w_chunk_a;
    logic [CHUNK-1:0]    w_chunk_b;
    logic                w_chunk_eq;
    logic                w_chunk_gt;
    logic                w_chunk_lt;
    logic                w_found;
    logic                w_ugt;
    logic                w_ult;
    logic                w_last;
    logic                w_finish;
    logic                w_sign_a;
    logic                w_sign_b;
    logic                w_sign_diff;
    logic                w_eq;
    logic                w_gt;
    logic                w_lt;

    // Select chunk r_idx of each captured operand
    assign w_base    = 32'(r_idx) * CHUNK;
    assign w_a_sh    = r_a >> w_base;
    assign w_b_sh    = r_b >> w_base;
    assign w_chunk_a = w_a_sh[CHUNK-1:0];
    assign w_chunk_b = w_b_sh[CHUNK-1:0];

    iterative_flagger_chunk_compare #(
        .CHUNK (CHUNK)
    ) u_chunk_compare (
        .i_a  (w_chunk_a),
        .i_b  (w_chunk_b),
        .o_eq (w_chunk_eq),
        .o_gt (w_chunk_gt),
        .o_lt (w_chunk_lt)
    );

    // Latch contents after this cycle's chunk has been considered
    assign w_found = r_found | ~w_chunk_eq;
    assign w_ugt   = r_found ? r_ugt : w_chunk_gt;
    assign w_ult   = r_found ? r_ult : w_chunk_lt;

    assign w_last   = (r_idx == '0);
    assign w_finish = (FIXED_LATENCY != 0) ? w_last : (w_last | ~w_chunk_eq);

    // With differing signs the sign bits alone decide the signed order
    assign w_sign_a    = r_a[WORDSIZE-1];
    assign w_sign_b    = r_b[WORDSIZE-1];
    assign w_sign_diff = w_sign_a ^ w_sign_b;
    assign w_eq        = ~w_found;
    assign w_gt        = w_sign_diff ? w_sign_b : w_ugt;
    assign w_lt        = w_sign_diff ? w_sign_a : w_ult;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_a        <= '0;
            r_b        <= '0;
            r_funct3   <= '0;
            r_idx      <= '0;
            r_found    <= 1'b0;
            r_ugt      <= 1'b0;
            r_ult      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_eq       <= 1'b0;
            r_gt       <= 1'b0;
            r_lt       <= 1'b0;
            r_ugt_flag <= 1'b0;
            r_ult_flag <= 1'b0;
            r_branch   <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_a      <= i_input_a;
                        r_b      <= i_input_b;
                        r_funct3 <= i_funct3;
                        r_idx    <= IdxTop;
                        r_found  <= 1'b0;
                        r_ugt    <= 1'b0;
                        r_ult    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= StScan;
                    end
                end
                StScan: begin
                    r_found <= w_found;
                    r_ugt   <= w_ugt;
                    r_ult   <= w_ult;
                    if (w_finish) begin
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_eq       <= w_eq;
                        r_gt       <= w_gt;
                        r_lt       <= w_lt;
                        r_ugt_flag <= w_ugt;
                        r_ult_flag <= w_ult;
                        r_branch   <= branch_decide(r_funct3, w_eq, w_lt, w_ult);
                        r_state    <= StDone;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    // Both equality flags stay 0 until the first result has been registered
    assign o_flag_equal     = r_eq;
    assign o_flag_not_equal = r_done_seen_ne();
    assign o_flag_greater   = r_gt;
    assign o_flag_less      = r_lt;
    assign o_flag_u_greater = r_ugt_flag;
    assign o_flag_u_less    = r_ult_flag;
    assign o_branch_taken   = r_branch;

    // not_equal is 1 only when a registered result exists and it was unequal
    function automatic logic r_done_seen_ne();
        return r_gt | r_lt | r_ugt_flag | r_ult_flag;
    endfunction

endmodule

// File: tb/tb_iterative_flagger.sv
// Scoreboard bench: two instances (early-exit and fixed-latency) share the
// stimulus; expected flags and done cycles are queued at issue and checked
// by a monitor when each done pulse appears.
module tb_iterative_flagger;

    localparam int unsigned W = 64;
    localparam int unsigned C = 16;
    localparam int unsigned N = W / C;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   f3;

    logic busy0, done0, eq0, ne0, gt0, lt0, ugt0, ult0, br0;
    logic busy1, done1, eq1, ne1, gt1, lt1, ugt1, ult1, br1;

    iterative_flagger #(
        .WORDSIZE      (W),
        .CHUNK         (C),
        .FIXED_LATENCY (0)
    ) dut0 (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_input_a        (in_a),
        .i_input_b        (in_b),
        .i_funct3         (f3),
        .o_busy           (busy0),
        .o_done           (done0),
        .o_flag_equal     (eq0),
        .o_flag_not_equal (ne0),
        .o_flag_greater   (gt0),
        .o_flag_less      (lt0),
        .o_flag_u_greater (ugt0),
        .o_flag_u_less    (ult0),
        .o_branch_taken   (br0)
    );

    iterative_flagger #(
        .WORDSIZE      (W),
        .CHUNK         (C),
        .FIXED_LATENCY (1)
    ) dut1 (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_input_a        (in_a),
        .i_input_b        (in_b),
        .i_funct3         (f3),
        .o_busy           (busy1),
        .o_done           (done1),
        .o_flag_equal     (eq1),
        .o_flag_not_equal (ne1),
        .o_flag_greater   (gt1),
        .o_flag_less      (lt1),
        .o_flag_u_greater (ugt1),
        .o_flag_u_less    (ult1),
        .o_branch_taken   (br1)
    );

    typedef struct {
        logic [7:0] flags;   // {busy, eq, ne, gt, lt, ugt, ult, br}
        int         cyc;
        string      name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vectors;
    int miscompares;
    int cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] fn);
        logic eq, ugt, ult, gt, lt, br;
        eq  = (a == b);
        ugt = (a > b);
        ult = (a < b);
        gt  = ($signed(a) > $signed(b));
        lt  = ($signed(a) < $signed(b));
        case (fn)
            3'b000:  br = eq;
            3'b001:  br = ~eq;
            3'b100:  br = lt;
            3'b101:  br = ~lt;
            3'b110:  br = ult;
            3'b111:  br = ~ult;
            default: br = 1'b0;
        endcase
        return {1'b0, eq, ~eq, gt, lt, ugt, ult, br};
    endfunction

    // Chunks scanned by the early-exit instance
    function automatic int early_k(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = N - 1; i >= 0; i--) begin
            if (a[i*C +: C] != b[i*C +: C]) return N - i;
        end
        return N;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t        e;
        logic [7:0]  got;
        if (rst_n && done0) begin
            vectors++;
            got = {busy0, eq0, ne0, gt0, lt0, ugt0, ult0, br0};
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL dut0_unexpected_done: got flags %b at cycle %0d, required none",
                         got, cyc);
            end else begin
                e = q0.pop_front();
                if (got !== e.flags || cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL dut0_%s: got flags %b cycle %0d, required flags %b cycle %0d",
                             e.name, got, cyc, e.flags, e.cyc);
                end
            end
        end
        if (rst_n && done1) begin
            vectors++;
            got = {busy1, eq1, ne1, gt1, lt1, ugt1, ult1, br1};
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL dut1_unexpected_done: got flags %b at cycle %0d, required none",
                         got, cyc);
            end else begin
                e = q1.pop_front();
                if (got !== e.flags || cyc !== e.cyc) begin
                    miscompares++;
                    $display("FAIL dut1_%s: got flags %b cycle %0d, required flags %b cycle %0d",
                             e.name, got, cyc, e.flags, e.cyc);
                end
            end
        end
    end

    // Wait for both instances to be idle, queue expectations, pulse start.
    // Start is sampled at the next posedge (cycle cyc+1); done appears k edges later.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] fn,
                         input string name);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while ((busy0 || busy1 || done0 || done1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_idle_timeout: still busy after %0d cycles, required idle", name, t);
        end
        e.flags = model(a, b, fn);
        e.name  = name;
        e.cyc   = cyc + 1 + early_k(a, b);
        q0.push_back(e);
        e.cyc   = cyc + 1 + N;
        q1.push_back(e);
        in_a  = a;
        in_b  = b;
        f3    = fn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 100);
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        rst_n = 1'b0;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        f3    = '0;
        repeat (3) @(negedge clk);
        outs = {busy0, done0, eq0, ne0, gt0, lt0, ugt0, ult0, br0,
                busy1, done1, eq1, ne1, gt1, lt1, ugt1, ult1, br1};
        vectors++;
        if (outs !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required all zero", outs);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        outs = {busy0, done0, eq0, ne0, gt0, lt0, ugt0, ult0, br0,
                busy1, done1, eq1, ne1, gt1, lt1, ugt1, ult1, br1};
        vectors++;
        if (outs !== 18'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b, required all zero", outs);
        end
    endtask

    task automatic test_directed();
        bit ok;
        issue(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b000, "equal_beq");
        issue(64'h8000_0000_0000_0000, 64'h1, 3'b100, "msb_diff_blt");
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 3'b111, "lsb_diff_bgeu");
        issue(64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 3'b101, "pos_vs_neg_bge");
        issue(64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 3'b010, "pos_vs_neg_f3_010");
        issue(64'h0000_1234_0000_0000, 64'h0000_1235_0000_0000, 3'b110, "mid_chunk_bltu");
        issue(64'h0000_1234_0000_0000, 64'h0000_1235_0000_0000, 3'b001, "mid_chunk_bne");
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL directed_drain: got %0d/%0d pending, required 0/0",
                     q0.size(), q1.size());
        end
    endtask

    task automatic test_ignored_start();
        bit   ok;
        logic was_busy;
        issue(64'hCAFE_0000_1111_2222, 64'hCAFE_0000_1111_2222, 3'b000, "ignored_first");
        was_busy = busy0;
        in_a  = 64'h1;
        in_b  = 64'h2;
        f3    = 3'b110;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        vectors++;
        if (was_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_busy_in_scan: got busy %b, required 1", was_busy);
        end
        drain(ok);
        repeat (10) @(negedge clk);
        vectors++;
        if (!ok || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_single_done: got ok %b busy %b%b, required ok 1 busy 00",
                     ok, busy0, busy1);
        end
    endtask

    task automatic test_back_to_back();
        bit           ok;
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            if (i % 2 == 0) b = a ^ (64'd1 << $urandom_range(63, 0));
            else            b = {$urandom, $urandom};
            issue(a, b, 3'($urandom_range(7, 0)), $sformatf("b2b_%0d", i));
        end
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_drain: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
        end
    endtask

    task automatic test_reset_mid_scan();
        bit          ok;
        logic        was_busy;
        logic [17:0] outs;
        issue(64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD, 3'b000, "aborted");
        @(negedge clk);
        was_busy = busy0 & busy1;
        #2 rst_n = 1'b0;
        #1;
        outs = {busy0, done0, eq0, ne0, gt0, lt0, ugt0, ult0, br0,
                busy1, done1, eq1, ne1, gt1, lt1, ugt1, ult1, br1};
        vectors++;
        if (was_busy !== 1'b1 || outs !== 18'd0) begin
            miscompares++;
            $display("FAIL async_reset_mid_scan: got busy_before %b outs %b, required 1 and zero",
                     was_busy, outs);
        end
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 3'b100, "after_reset_blt");
        drain(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL after_reset_drain: got %0d/%0d pending, required 0/0",
                     q0.size(), q1.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_scan();
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iterative_flagger.md
Name: iterative_flagger

Overview:
Multi-cycle, parametrised successor of the ALU flag unit. Compares two WORDSIZE operands CHUNK bits at a time, starting at the MSB chunk, and produces registered signed, unsigned and equality flags plus a RISC-V branch decision from funct3. It sits beside the ALU in the execute stage and serves narrow or area-constrained cores that cannot afford a full-width comparator. A start/busy/done handshake allows the stage to stall on it.

Parameters:
WORDSIZE, 64, operand width in bits.
CHUNK, 16, bits compared per cycle. Must divide WORDSIZE; N = WORDSIZE/CHUNK.
FIXED_LATENCY, 0, 1 = always scan all N chunks (constant time); 0 = stop at the first differing chunk.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
input_a  input  WORDSIZE  first operand; captured on an accepted start.
input_b  input  WORDSIZE  second operand; captured on an accepted start.
funct3  input  3  branch type; captured on an accepted start.
busy  output  1  high from the cycle after acceptance until done.
done  output  1  one-cycle pulse; flags are valid from this cycle.
flag_equal, flag_not_equal  output  1 each  equality flags.
flag_greater, flag_less  output  1 each  signed (two's complement) compare flags.
flag_u_greater, flag_u_less  output  1 each  unsigned compare flags.
branch_taken  output  1  branch decision for the captured funct3.

Behaviour:
- Reset (asynchronous, any state, including mid-scan): state becomes IDLE. busy, done, all flags and branch_taken are 0, including flag_not_equal. Captured operands are cleared.
- States: IDLE, SCAN, DONE.
- IDLE: if start=1, capture a, b and funct3, set idx=N-1, clear the result latch, go to SCAN. Otherwise stay in IDLE; outputs hold their last values.
- SCAN: compare chunk idx (unsigned) of the captured operands.
  - On the first differing chunk, latch ugt/ult from that chunk's comparison. Later chunks never overwrite the latch.
  - FIXED_LATENCY=0: go to DONE when a difference is latched or when idx==0. Otherwise decrement idx.
  - FIXED_LATENCY=1: go to DONE only when idx==0.
- DONE (one cycle): done=1, busy=0. Flags and branch_taken are registered on entry and held until the next accepted start. Next state is IDLE.
- Latency: a start sampled at edge t gives done high in cycle t+k+1, where k is the number of chunks scanned.
  - FIXED_LATENCY=0: k is 1..N.
  - FIXED_LATENCY=1: k = N.
- Back-to-back: start is sampled again only in IDLE, so minimum issue interval is k+2 cycles.
- start while in SCAN or DONE is ignored. No queueing, no error.
- Flag derivation:
  - equal = no differing chunk; not_equal = ~equal.
  - u_greater and u_less are the latched ugt and ult (both 0 when equal).
  - Signs equal: signed flags = unsigned flags.
  - Signs differ: greater = sign_b, less = sign_a.
- branch_taken by funct3:
  - 000 = equal.
  - 001 = not_equal.
  - 100 = less.
  - 101 = ~less.
  - 110 = u_less.
  - 111 = ~u_less.
  - 010 and 011 give 0.
- Exactly one of {equal, greater, less} is 1 and exactly one of {equal, u_greater, u_less} is 1 at every done.

Decomposition:
- Shared package: funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the state encoding (IDLE, SCAN, DONE).
- One combinational sub-module, chunk_compare, parametrised on CHUNK. It outputs eq, gt and lt for one chunk and is instantiated once, muxed by idx.
- Static elaboration check: WORDSIZE % CHUNK == 0 and CHUNK >= 1.

Test Plan:
- Defaults, a = b = 0x0123_4567_89AB_CDEF, funct3=000, start at t -> done at t+5; equal=1, not_equal=0, all greater/less 0, branch_taken=1.
- a = 0x8000_0000_0000_0000, b = 1, funct3=100 -> done at t+2; u_greater=1, less=1, greater=0, branch_taken=1. Same stimulus with FIXED_LATENCY=1 -> done at t+5 with identical flags.
- a = 0xFFFF_FFFF_FFFF_FFFF, b = 0xFFFF_FFFF_FFFF_FFFE, funct3=111 -> done at t+5; u_greater=1, greater=1, branch_taken=1.
- a = 5, b = 0xFFFF_FFFF_FFFF_FFFB (−5), funct3=101 -> greater=1, u_less=1, branch_taken=1. Then funct3=010 with the same operands -> branch_taken=0.
- start pulsed during SCAN with different operands -> ignored; done occurs once with the first request's flags.
- rst_n low mid-SCAN -> busy, done and all flags drop to 0 immediately (asynchronous). After release, a new start completes normally.
